// File: rtl/pc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pc_pkg
// Brief    : Shared defaults and types for the program counter slice.
// Revision : 1.0  initial release
// ============================================================================
package pc_pkg;

    localparam int          PC_WIDTH        = 32;
    localparam logic [31:0] PC_RESET_VECTOR = 32'h0000_0000;
    localparam int          PC_INCR         = 4;

    typedef logic [PC_WIDTH-1:0] pc_t;

endpackage : pc_pkg
`default_nettype wire

// File: rtl/pc_en_reg.sv
`default_nettype none
// ============================================================================
// Module   : pc_en_reg
// Brief    : Generic WIDTH-bit register with load enable and asynchronous
//            active-high reset to RESET_VALUE.
// Revision : 1.0  initial release
// ============================================================================
module pc_en_reg
    import pc_pkg::*;
#(
    parameter int               WIDTH       = PC_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;

    // Next state: take the new value when enabled, otherwise hold.
    always_comb begin
        data_d = data_q;
        if (enable_i) begin
            data_d = d_i;
        end
    end

    // State register; reset clears immediately, independent of the clock.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q <= RESET_VALUE;
        end else begin
            data_q <= data_d;
        end
    end

    assign q_o = data_q;

endmodule : pc_en_reg
`default_nettype wire

// File: rtl/pc.sv
`default_nettype none
// ============================================================================
// Module   : pc
// Brief    : Program counter register with sequential (+INCR) address output.
//            Optional macro PC_MISALIGN_FLAG_EN adds a 'misaligned' output
//            and a simulation-time check on misaligned loads.
// Revision : 1.0  initial release
// ============================================================================
module pc
    import pc_pkg::*;
#(
    parameter int          WIDTH        = PC_WIDTH,
    parameter logic [31:0] RESET_VECTOR = PC_RESET_VECTOR,
    parameter int          INCR         = PC_INCR
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] q_out,
    output logic [WIDTH-1:0] q_plus
`ifdef PC_MISALIGN_FLAG_EN
    ,
    output logic             misaligned
`endif
);

    // Reset vector and increment narrowed to the address width.
    localparam logic [WIDTH-1:0] C_RESET_VALUE = WIDTH'(RESET_VECTOR);
    localparam logic [WIDTH-1:0] C_INCR        = WIDTH'(INCR);

    // Stored value is kept bit-exact; no alignment masking on load.
    pc_en_reg #(
        .WIDTH       (WIDTH),
        .RESET_VALUE (C_RESET_VALUE)
    ) u_pc_reg (
        .clk      (clk),
        .reset    (reset),
        .enable_i (enable),
        .d_i      (data_in),
        .q_o      (q_out)
    );

    // Sequential fetch address; wraps modulo 2^WIDTH, carry discarded.
    always_comb begin
        q_plus = q_out + C_INCR;
    end

`ifdef PC_MISALIGN_FLAG_EN
    // Flag any current PC that is not word aligned.
    always_comb begin
        misaligned = |q_out[1:0];
    end

`ifndef SYNTHESIS
    // Report misaligned addresses at the moment they are loaded.
    always @(posedge clk) begin
        if (!reset && enable) begin
            assert (data_in[1:0] == 2'b00)
            else $error("pc: misaligned load 0x%h", data_in);
        end
    end
`endif
`endif

endmodule : pc
`default_nettype wire

// File: tb/tb_pc.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc
// Brief    : Directed self-checking bench for the program counter.
// Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_pc;

    logic        clk;
    logic        reset;
    logic        enable;
    logic [31:0] data_in;
    logic [31:0] q_out;
    logic [31:0] q_plus;
`ifdef PC_MISALIGN_FLAG_EN
    logic        misaligned;
`endif

    int passed = 0;
    int total  = 0;

    pc #(
        .WIDTH        (32),
        .RESET_VECTOR (32'h0000_0000),
        .INCR         (4)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .enable  (enable),
        .data_in (data_in),
        .q_out   (q_out),
        .q_plus  (q_plus)
`ifdef PC_MISALIGN_FLAG_EN
        ,
        .misaligned (misaligned)
`endif
    );

    // 10 ns clock, rising edges at 5, 15, 25 ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
    endtask

    // Drive data at the falling edge, then sample 1 ns after the next rising edge.
    task automatic load_step(input logic en, input logic [31:0] d);
        @(negedge clk);
        enable  = en;
        data_in = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset   = 1'b0;
        enable  = 1'b1;
        data_in = 32'h0000_1234;

        // Mid-cycle reset clears without a clock edge.
        #2 reset = 1'b1;
        #1;
        check("reset_async_q", q_out, 32'h0000_0000);
        check("reset_async_qplus", q_plus, 32'h0000_0004);
        @(posedge clk); #1;
        check("reset_hold_edge1", q_out, 32'h0000_0000);
        @(posedge clk); #1;
        check("reset_hold_edge2", q_out, 32'h0000_0000);

        // Release and load sequence.
        @(negedge clk);
        reset = 1'b0;
        load_step(1'b1, 32'h0000_F732);
        check("load_f732", q_out, 32'h0000_F732);
        check("qplus_f732", q_plus, 32'h0000_F736);
`ifdef PC_MISALIGN_FLAG_EN
        check("misaligned_f732", {31'd0, misaligned}, 32'd1);
`endif
        load_step(1'b1, 32'h0000_A333);
        check("load_a333", q_out, 32'h0000_A333);
        check("qplus_a333", q_plus, 32'h0000_A337);
`ifdef PC_MISALIGN_FLAG_EN
        load_step(1'b1, 32'h0000_A330);
        check("misaligned_a330", {31'd0, misaligned}, 32'd0);
`endif

        // Stall: enable low holds across three edges.
        load_step(1'b1, 32'h0000_0040);
        check("load_40", q_out, 32'h0000_0040);
        load_step(1'b0, 32'hDEAD_BEEF);
        check("stall_edge1", q_out, 32'h0000_0040);
        @(posedge clk); #1;
        check("stall_edge2", q_out, 32'h0000_0040);
        @(posedge clk); #1;
        check("stall_edge3", q_out, 32'h0000_0040);
        check("stall_qplus", q_plus, 32'h0000_0044);
        load_step(1'b1, 32'hDEAD_BEEF);
        check("unstall_load", q_out, 32'hDEAD_BEEF);
        check("unstall_qplus", q_plus, 32'hDEAD_BEF3);

        // Wrap of the incrementer.
        load_step(1'b1, 32'hFFFF_FFFC);
        check("wrap_fffc_q", q_out, 32'hFFFF_FFFC);
        check("wrap_fffc_qplus", q_plus, 32'h0000_0000);
        load_step(1'b1, 32'hFFFF_FFFF);
        check("wrap_ffff_qplus", q_plus, 32'h0000_0003);

        // Reset coincident with a rising edge dominates the load.
        @(negedge clk);
        enable  = 1'b1;
        data_in = 32'h0000_0055;
        @(posedge clk);
        reset = 1'b1;
        #1;
        check("reset_at_edge", q_out, 32'h0000_0000);
        #2 reset = 1'b0;
        #1;
        check("after_release_no_edge", q_out, 32'h0000_0000);
        @(posedge clk); #1;
        check("release_load_55", q_out, 32'h0000_0055);
        check("release_qplus_59", q_plus, 32'h0000_0059);

        // Mid-cycle reset with enable low still clears at once.
        @(negedge clk);
        enable = 1'b0;
        #1 reset = 1'b1;
        #1;
        check("midcycle_reset_en0", q_out, 32'h0000_0000);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        check("release_en0_hold", q_out, 32'h0000_0000);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule : tb_pc
`default_nettype wire
